// File: rtl/hash160_arbiter.sv
// Round-robin arbiter that shares a single Hash160 engine among N_REQ requesters.
// Each transaction is one pre-padded 512-bit block; a watchdog turns hung engine runs into error responses.
module hash160_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*512-1:0] req_block,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 eng_start,
  output logic [511:0]         eng_block,
  input  logic                 eng_done,
  input  logic [159:0]         eng_digest,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [159:0]         rsp_digest,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 spurious
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [15:0]     TO_LIMIT  = 16'(TIMEOUT);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N_REQ - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [ID_W-1:0] last;
  logic [15:0]     wd_cnt;

  logic [ID_W-1:0] scan_idx;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;

  logic [511:0] blk [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign blk[g] = req_block[g*512 +: 512];
  end

  // Walk the requesters starting just after the previous winner; the first valid one wins.
  // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = last;
    if (state == S_IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        scan_idx = (scan_idx == LAST_INIT) ? '0 : scan_idx + ID_W'(1);
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any           = 1'b1;
          grant_idx           = scan_idx;
          req_ready[scan_idx] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (eng_done || wd_cnt == TO_LIMIT) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last       <= LAST_INIT;
      wd_cnt     <= '0;
      eng_start  <= 1'b0;
      eng_block  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_digest <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      spurious   <= 1'b0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      eng_start <= (state == S_IDLE) && grant_any;

      // A completion outside WAIT has no owner; flag it and keep it.
      if (eng_done && state != S_WAIT) spurious <= 1'b1;

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            eng_block <= blk[grant_idx];
            rsp_id    <= grant_idx;
            last      <= grant_idx;
          end
        end
        S_ISSUE: wd_cnt <= '0;
        S_WAIT: begin
          // Done is tested first so a completion on the timeout cycle still returns data.
          if (eng_done) begin
            rsp_digest <= eng_digest;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
          end else if (wd_cnt == TO_LIMIT) begin
            rsp_digest <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        S_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hash160_arbiter.sv
// Randomized self-checking bench for hash160_arbiter: engine model, grant-order model and per-transaction timing checks.
module tb_hash160_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;
  localparam int TO   = 8;

  localparam logic [511:0] ABC_BLOCK  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [159:0] ABC_DIGEST = 160'hbb1be98c142444d7a32e0a5e6e0e3a1a0f3c8a0a;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*512-1:0] req_block;
  logic [N-1:0]   req_ready;
  logic           eng_start;
  logic [511:0]   eng_block;
  logic           eng_done;
  logic           eng_done_m = 1'b0;
  logic           inj_done = 1'b0;
  logic [159:0]   eng_digest = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [ID_W-1:0] rsp_id;
  logic [159:0]   rsp_digest;
  logic           rsp_err;
  logic           busy;
  logic           spurious;

  logic [511:0] blocks [N];
  int           eng_lat = 0;
  int           model_last = N - 1;
  logic [159:0] last_digest;
  int           n_checks = 0;
  int           n_pass = 0;

  assign eng_done = eng_done_m | inj_done;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_block[g*512 +: 512] = blocks[g];
  end

  hash160_arbiter #(.N_REQ(N), .ID_W(ID_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_block(req_block), .req_ready(req_ready),
    .eng_start(eng_start), .eng_block(eng_block),
    .eng_done(eng_done), .eng_digest(eng_digest),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_digest(rsp_digest), .rsp_err(rsp_err),
    .busy(busy), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Stand-in for the real engine: "abc" gets its true Hash160, anything else a fixed fold.
  function automatic logic [159:0] fake_digest(input logic [511:0] b);
    if (b == ABC_BLOCK) return ABC_DIGEST;
    return b[511:352] ^ b[351:192] ^ b[191:32] ^ {b[31:0], 128'h0} ^ 160'hc3d2e1f0_10325476_98badcfe_efcdab89_67452301;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom)};
    return b;
  endfunction

  // Next winner: first valid requester at last+1, last+2, ... modulo N.
  function automatic int model_grant(input logic [N-1:0] v, input int last_id);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (last_id + i) % N;
      if (v[c[ID_W-1:0]]) return c;
    end
    return -1;
  endfunction

  // Engine: eng_lat cycles after a start it pulses done with the digest; eng_lat==0 never completes.
  initial begin
    int left;
    logic pending;
    logic [159:0] pend_dig;
    pending = 1'b0;
    left = 0;
    pend_dig = '0;
    forever begin
      @(negedge clk);
      eng_done_m = 1'b0;
      eng_digest = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (pending) begin
        left--;
        if (left == 0) begin
          eng_done_m = 1'b1;
          eng_digest = pend_dig;
          pending = 1'b0;
        end
      end
      if (eng_start && eng_lat > 0) begin
        pending  = 1'b1;
        left     = eng_lat;
        pend_dig = fake_digest(eng_block);
      end
    end
  end

  task automatic check_reset(input string pfx);
    check({pfx, "_req_ready"}, 512'(req_ready), 512'(0));
    check({pfx, "_eng_start"}, 512'(eng_start), 512'(0));
    check({pfx, "_eng_block"}, eng_block, 512'(0));
    check({pfx, "_rsp_valid"}, 512'(rsp_valid), 512'(0));
    check({pfx, "_rsp_id"}, 512'(rsp_id), 512'(0));
    check({pfx, "_rsp_digest"}, 512'(rsp_digest), 512'(0));
    check({pfx, "_rsp_err"}, 512'(rsp_err), 512'(0));
    check({pfx, "_busy"}, 512'(busy), 512'(0));
    check({pfx, "_spurious"}, 512'(spurious), 512'(0));
  endtask

  // One full transaction, entered at a falling edge with the DUT idle and req_valid already set.
  // lat==0 models a hung engine; bp>0 holds rsp_ready low for bp cycles after the response appears.
  task automatic one_txn(input int lat, input int bp);
    int exp_id;
    int exp_n;
    int n;
    logic timed_out;
    logic ok;
    logic [511:0] blk;
    logic [159:0] exp_dig;
    logic [159:0] d0;
    rsp_ready = (bp == 0);
    eng_lat   = lat;
    #1;
    exp_id = model_grant(req_valid, model_last);
    check("grant", 512'(req_ready), (exp_id < 0) ? 512'(0) : 512'(N'(1) << exp_id));
    if (exp_id < 0) return;
    model_last = exp_id;
    blk        = blocks[exp_id[ID_W-1:0]];
    timed_out  = (lat == 0) || (lat > TO + 1);
    exp_n      = timed_out ? TO + 2 : lat + 1;
    exp_dig    = timed_out ? '0 : fake_digest(blk);

    @(negedge clk);
    check("eng_start", 512'(eng_start), 512'(1));
    check("eng_block", eng_block, blk);
    check("busy_issue", 512'(busy), 512'(1));
    blocks[exp_id[ID_W-1:0]] = rand_block();

    n = 0;
    while (!rsp_valid && n < TO + 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", 512'(n), 512'(exp_n));
    check("rsp_id", 512'(rsp_id), 512'(exp_id));
    check("rsp_digest", 512'(rsp_digest), 512'(exp_dig));
    check("rsp_err", 512'(rsp_err), 512'(timed_out));
    check("ready_in_resp", 512'(req_ready), 512'(0));
    last_digest = rsp_digest;

    if (bp > 0) begin
      ok = 1'b1;
      d0 = rsp_digest;
      repeat (bp) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id[ID_W-1:0] || rsp_digest !== d0 ||
            rsp_err !== timed_out || req_ready !== '0) ok = 1'b0;
      end
      check("bp_hold", 512'(ok), 512'(1));
      rsp_ready = 1'b1;
    end

    @(negedge clk);
    check("rsp_drop", 512'(rsp_valid), 512'(0));
    check("busy_idle", 512'(busy), 512'(0));
  endtask

  initial begin
    int served [N];
    logic ok;
    for (int i = 0; i < N; i++) begin
      blocks[i] = rand_block();
      served[i] = 0;
    end

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst_rel");

    // Single request from requester 2 with the padded "abc" block.
    blocks[2]  = ABC_BLOCK;
    req_valid  = 4'b0100;
    one_txn(5, 0);
    check("abc_digest", 512'(last_digest), 512'(ABC_DIGEST));

    // Fairness: everyone valid, each id served once per four grants.
    req_valid = '1;
    for (int t = 0; t < 8; t++) begin
      one_txn(int'($urandom_range(1, 6)), 0);
      served[model_last]++;
    end
    for (int i = 0; i < N; i++) check("fair_count", 512'(served[i]), 512'(2));

    // Backpressure for ten cycles, then the next grant immediately after.
    one_txn(3, 10);
    one_txn(2, 0);

    // Random request masks, latencies up to the timeout boundary, random backpressure.
    for (int t = 0; t < 20; t++) begin
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      one_txn(int'($urandom_range(1, TO + 1)), int'($urandom_range(0, 3)));
    end
    check("no_spurious_yet", 512'(spurious), 512'(0));

    // Done arrives on exactly the cycle the watchdog expires.
    req_valid = 4'b0001;
    one_txn(TO + 1, 0);

    // Hung engine: error response, then a late done is flagged without a response.
    req_valid = 4'b1000;
    one_txn(0, 0);
    req_valid = '0;
    inj_done  = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check("spurious_set", 512'(spurious), 512'(1));
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("no_extra_rsp", 512'(ok), 512'(1));

    // Reset in the middle of WAIT.
    eng_lat   = 0;
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 512'(busy), 512'(1));
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("no_stale_rsp", 512'(ok), 512'(1));
    req_valid = 4'b1001;
    one_txn(4, 0);
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
